// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
//   Folds PS/2 Set-2 prefix sequences (E0 extended, F0 break, E1 pause) into
//   16-bit key events and queues them in a circular FIFO drained by the CPU
//   side with a valid/ready handshake. Device status bytes are diverted to a
//   separate status port.
//
// Ports
//   clk_i, reset_i         single clock, synchronous active-high reset
//   byte_i, byte_valid_i   received scan code byte and its one-cycle strobe
//   byte_error_i           parity/framing error, qualified by byte_valid_i
//   event_o                FIFO head {break, extended, 6'b0, code}; 0 when empty
//   event_valid_o          FIFO non-empty
//   event_ready_i          pops the head when event_valid_o is high
//   status_o/_valid_o      last status byte and its one-cycle update pulse
//   overflow_o             sticky dropped-event flag, cleared by overflow_clear_i
//   error_count_o          saturating count of errored bytes
module ps2_scancode_decoder #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  input  logic        byte_error_i,
  output logic [15:0] event_o,
  output logic        event_valid_o,
  input  logic        event_ready_i,
  output logic [7:0]  status_o,
  output logic        status_valid_o,
  output logic        overflow_o,
  input  logic        overflow_clear_i,
  output logic [7:0]  error_count_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_PAUSE
  } state_t;

  state_t      state;
  logic [2:0]  skip_cnt;

  logic [15:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  logic        good_byte;
  logic        bad_byte;
  logic        is_status;
  logic        push_req;
  logic [15:0] push_data;
  logic        full;
  logic        empty;
  logic        pop;
  logic        wr_en;

  assign good_byte = byte_valid_i && !byte_error_i;
  assign bad_byte  = byte_valid_i && byte_error_i;

  always_comb begin
    is_status = 1'b0;
    case (byte_i)
      8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF: is_status = 1'b1;
      default: is_status = 1'b0;
    endcase
  end

  // Event decode for the current byte; the FSM below only tracks prefixes.
  always_comb begin
    push_req  = 1'b0;
    push_data = '0;
    if (good_byte) begin
      case (state)
        S_IDLE: begin
          if (byte_i != 8'hE0 && byte_i != 8'hF0 && byte_i != 8'hE1 && !is_status) begin
            push_req  = 1'b1;
            push_data = {8'h00, byte_i};
          end
        end
        S_EXT: begin
          if (byte_i != 8'hF0 && byte_i != 8'hE0) begin
            push_req  = 1'b1;
            push_data = {8'h40, byte_i};
          end
        end
        S_BRK: begin
          push_req  = 1'b1;
          push_data = {8'h80, byte_i};
        end
        S_EXT_BRK: begin
          push_req  = 1'b1;
          push_data = {8'hC0, byte_i};
        end
        S_PAUSE: begin
          // Seventh byte after E1 closes the pause sequence.
          if (skip_cnt <= 3'd1) begin
            push_req  = 1'b1;
            push_data = 16'h00E1;
          end
        end
        default: begin
          push_req  = 1'b0;
          push_data = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state          <= S_IDLE;
      skip_cnt       <= '0;
      status_o       <= '0;
      status_valid_o <= 1'b0;
      error_count_o  <= '0;
    end else begin
      status_valid_o <= 1'b0;
      if (bad_byte) begin
        state    <= S_IDLE;
        skip_cnt <= '0;
        if (error_count_o != 8'hFF) error_count_o <= error_count_o + 8'd1;
      end else if (good_byte) begin
        case (state)
          S_IDLE: begin
            if (byte_i == 8'hE0) begin
              state <= S_EXT;
            end else if (byte_i == 8'hF0) begin
              state <= S_BRK;
            end else if (byte_i == 8'hE1) begin
              state    <= S_PAUSE;
              skip_cnt <= 3'd7;
            end else if (is_status) begin
              status_o       <= byte_i;
              status_valid_o <= 1'b1;
            end
          end
          S_EXT: begin
            if (byte_i == 8'hF0) state <= S_EXT_BRK;
            else if (byte_i != 8'hE0) state <= S_IDLE;
          end
          S_BRK, S_EXT_BRK: state <= S_IDLE;
          S_PAUSE: begin
            if (skip_cnt <= 3'd1) begin
              state    <= S_IDLE;
              skip_cnt <= '0;
            end else begin
              skip_cnt <= skip_cnt - 3'd1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && event_ready_i;
  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign wr_en = push_req && (!full || pop);

  assign event_valid_o = !empty;
  assign event_o       = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      if (push_req && !wr_en) overflow_o <= 1'b1;
      else if (overflow_clear_i) overflow_o <= 1'b0;
    end
  end

endmodule
